// File: rtl/id_hazard_ctrl.sv
// Hazard and stall scheduler for the IF/ID/EX front end.
// Decodes load-use hazards, data-memory wait states and MEM-stage branch
// flushes into PC / IF/ID / ID/EX enables, the ID/EX bubble and flushes.
// Optional feature macro: HAZ_PERF_CNT_EN (stall / flush performance counters).
module id_hazard_ctrl #(
    parameter int unsigned REG_W       = 5,
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             idex_memread,
    input  logic [REG_W-1:0] idex_rt,
    input  logic             mem_busy,
    input  logic             branch_taken,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_bubble,
    output logic             exmem_flush,
    output logic [1:0]       state,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int unsigned WAIT_W      = 8;
    localparam logic [WAIT_W-1:0] WAIT_MAX    = '1;
    localparam logic [WAIT_W-1:0] TIMEOUT_LIM = WAIT_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_FLUSH    = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_nxt;
    logic [WAIT_W-1:0] wait_q;
    logic [WAIT_W-1:0] wait_nxt;
    logic              timeout_q;
    logic              timeout_set;
    logic              lu_hazard;
    logic              rs_match;
    logic              rt_match;

    assign state       = state_q;
    assign mem_timeout = timeout_q;

    // Load in EX whose destination feeds the instruction in ID ($zero never hazards)
    always_comb begin
        rs_match  = (idex_rt == id_rs);
        rt_match  = id_uses_rt && (idex_rt == id_rt);
        lu_hazard = idex_memread && (idex_rt != '0) && (rs_match || rt_match);
    end

    // Next state and Mealy outputs; priority rst > branch_taken > mem_busy > lu_hazard
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_write  = 1'b1;
        idex_bubble = 1'b0;
        exmem_flush = 1'b0;
        state_nxt   = state_q;
        wait_nxt    = wait_q;
        timeout_set = 1'b0;

        if (rst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            exmem_flush = 1'b1;
            state_nxt   = ST_RUN;
            wait_nxt    = '0;
        end else if (branch_taken) begin
            // PC loads the branch target; squash the wrong-path instructions
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            exmem_flush = 1'b1;
            state_nxt   = ST_FLUSH;
            wait_nxt    = '0;
        end else if (mem_busy) begin
            // Full freeze while the data memory is not ready
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_write = 1'b0;
            state_nxt  = ST_MEM_WAIT;
            if (state_q == ST_MEM_WAIT) begin
                if (wait_q >= TIMEOUT_LIM) begin
                    timeout_set = 1'b1;
                end
                if (wait_q != WAIT_MAX) begin
                    wait_nxt = wait_q + WAIT_W'(1);
                end
            end else begin
                wait_nxt = WAIT_W'(1);
            end
        end else begin
            wait_nxt  = '0;
            state_nxt = ST_RUN;
            // LU_STALL and FLUSH hold a bubble / flushed slot in ID/EX, so only
            // RUN and the cycle leaving MEM_WAIT can see a real load-use hazard
            if (((state_q == ST_RUN) || (state_q == ST_MEM_WAIT)) && lu_hazard) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
                state_nxt   = ST_LU_STALL;
            end
        end
    end

    // State register, memory wait counter and sticky timeout flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_RUN;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_nxt;
            wait_q  <= wait_nxt;
            if (timeout_set) begin
                timeout_q <= 1'b1;
            end
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;

    // Saturating counts of stalled cycles and applied branch flushes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_write && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (exmem_flush && (flush_q != '1)) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed bench for id_hazard_ctrl: expected output vectors are queued when
// each step is driven and popped when the DUT's combinational response is sampled.
module tb_id_hazard_ctrl;

    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 16;

`ifdef HAZ_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_flush}
    localparam logic [5:0] O_DEF = 6'b110100;
    localparam logic [5:0] O_LU  = 6'b000110;
    localparam logic [5:0] O_FRZ = 6'b000000;
    localparam logic [5:0] O_FL  = 6'b111111;
    localparam logic [5:0] O_RST = 6'b001111;

    logic             clk;
    logic             rst;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rt;
    logic             idex_memread;
    logic [REG_W-1:0] idex_rt;
    logic             mem_busy;
    logic             branch_taken;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_write;
    logic             idex_bubble;
    logic             exmem_flush;
    logic [1:0]       state;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    int checks = 0;
    int errors = 0;

    logic [8:0] exp_q[$];
    string      tag_q[$];

    id_hazard_ctrl #(.REG_W(REG_W), .MEM_TIMEOUT(15), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .idex_memread (idex_memread),
        .idex_rt      (idex_rt),
        .mem_busy     (mem_busy),
        .branch_taken (branch_taken),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .ifid_flush   (ifid_flush),
        .idex_write   (idex_write),
        .idex_bubble  (idex_bubble),
        .exmem_flush  (exmem_flush),
        .state        (state),
        .mem_timeout  (mem_timeout),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [8:0] observe();
        return {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
                exmem_flush, state, mem_timeout};
    endfunction

    task automatic check_vec(input string tag, input logic [8:0] exp);
        logic [8:0] obs;
        obs = observe();
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_cnt(input string tag, input logic [CNT_W-1:0] obs,
                             input int exp_val);
        logic [CNT_W-1:0] exp;
        exp = PERF ? CNT_W'(exp_val) : '0;
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One cycle: drive after the edge, queue the expectation, compare at the falling edge
    task automatic step(input string tag, input int rs, input int rt, input int urt,
                        input int mr, input int xrt, input int busy, input int br,
                        input logic [5:0] outs, input int st, input int to);
        logic [8:0] e;
        string      t;
        @(posedge clk);
        #2;
        id_rs        = REG_W'(rs);
        id_rt        = REG_W'(rt);
        id_uses_rt   = 1'(urt);
        idex_memread = 1'(mr);
        idex_rt      = REG_W'(xrt);
        mem_busy     = 1'(busy);
        branch_taken = 1'(br);
        exp_q.push_back({outs, 2'(st), 1'(to)});
        tag_q.push_back(tag);
        @(negedge clk);
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check_vec(t, e);
    endtask

    task automatic idle(input string tag, input int st, input int to);
        step(tag, 0, 0, 0, 0, 0, 0, 0, O_DEF, st, to);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2;
        rst          = 1'b1;
        mem_busy     = 1'b0;
        branch_taken = 1'b0;
        idex_memread = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        id_rs        = '0;
        id_rt        = '0;
        id_uses_rt   = 1'b0;
        idex_memread = 1'b0;
        idex_rt      = '0;
        mem_busy     = 1'b0;
        branch_taken = 1'b0;

        // Reset pattern
        #12;
        check_vec("reset_outputs", {O_RST, 2'd0, 1'b0});
        check_cnt("reset_stall_cnt", stall_cycles, 0);
        check_cnt("reset_flush_cnt", flush_count, 0);
        #1 rst = 1'b0;

        // Load-use stall
        step("lu_stall",  8, 0, 0, 1, 8, 0, 0, O_LU,  0, 0);
        step("lu_hold",   8, 0, 0, 1, 8, 0, 0, O_DEF, 1, 0);
        idle("lu_back", 0, 0);

        // $zero, rt masking, no memread
        step("zero_reg",   0, 0, 0, 1, 0, 0, 0, O_DEF, 0, 0);
        step("rt_masked",  3, 9, 0, 1, 9, 0, 0, O_DEF, 0, 0);
        step("no_memread", 8, 0, 0, 0, 8, 0, 0, O_DEF, 0, 0);
        step("rt_used",    3, 9, 1, 1, 9, 0, 0, O_LU,  0, 0);
        idle("rt_stall_st", 1, 0);
        idle("rt_back", 0, 0);

        // Memory wait, 3 busy cycles
        pulse_reset();
        step("mw_1", 0, 0, 0, 0, 0, 1, 0, O_FRZ, 0, 0);
        step("mw_2", 0, 0, 0, 0, 0, 1, 0, O_FRZ, 2, 0);
        step("mw_3", 0, 0, 0, 0, 0, 1, 0, O_FRZ, 2, 0);
        idle("mw_release", 2, 0);
        check_cnt("mw_stall_cnt", stall_cycles, 3);
        idle("mw_run", 0, 0);

        // Leaving MEM_WAIT straight into a load-use stall
        step("mwlu_busy", 0, 0, 0, 0, 0, 1, 0, O_FRZ, 0, 0);
        step("mwlu_haz",  8, 0, 0, 1, 8, 0, 0, O_LU,  2, 0);
        idle("mwlu_stall_st", 1, 0);
        idle("mwlu_run", 0, 0);

        // Timeout after 16 consecutive busy cycles (MEM_TIMEOUT = 15)
        for (int i = 1; i <= 16; i++) begin
            step($sformatf("to_busy_%0d", i), 0, 0, 0, 0, 0, 1, 0, O_FRZ,
                 (i == 1) ? 0 : 2, 0);
        end
        idle("to_release", 2, 1);
        idle("to_sticky_a", 0, 1);
        idle("to_sticky_b", 0, 1);

        // Asynchronous reset in the middle of MEM_WAIT
        step("rmw_busy_a", 0, 0, 0, 0, 0, 1, 0, O_FRZ, 0, 1);
        step("rmw_busy_b", 0, 0, 0, 0, 0, 1, 0, O_FRZ, 2, 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_vec("async_rst_now", {O_RST, 2'd0, 1'b0});
        check_cnt("async_rst_stall", stall_cycles, 0);
        check_cnt("async_rst_flush", flush_count, 0);
        @(posedge clk);
        #1;
        check_vec("async_rst_held", {O_RST, 2'd0, 1'b0});
        mem_busy = 1'b0;
        #1 rst = 1'b0;
        idle("post_rst", 0, 0);

        // Branch colliding with load-use and mem_busy
        step("collide", 8, 0, 0, 1, 8, 1, 1, O_FL, 0, 0);
        idle("collide_flush_st", 3, 0);
        check_cnt("collide_flush_cnt", flush_count, 1);
        check_cnt("collide_stall_cnt", stall_cycles, 0);
        idle("collide_run", 0, 0);

        // Branch inside MEM_WAIT; hazard ignored in FLUSH
        step("brmw_busy",  0, 0, 0, 0, 0, 1, 0, O_FRZ, 0, 0);
        step("brmw_br",    0, 0, 0, 0, 0, 1, 1, O_FL,  2, 0);
        step("flush_nolu", 8, 0, 0, 1, 8, 0, 0, O_DEF, 3, 0);
        idle("brmw_run", 0, 0);
        check_cnt("final_flush_cnt", flush_count, 2);
        check_cnt("final_stall_cnt", stall_cycles, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
